// File: rtl/contador_ocupacion.sv
// Purpose : occupancy counter for a two-beam gate (A outside, B inside) with
//           input conditioning, direction FSM and saturating up/down count.
// Latency : pin change -> debounced level 2+DEB_CYCLES cycles; COUNT and the
//           event pulses update one cycle after the debounced pair completes a
//           sequence.
// Backpr. : none; sensors are free-running levels, nothing can be stalled.
//
// Ports:
//   CLK      rising-edge clock for all logic
//   RST      asynchronous active-low reset
//   BTN_A    outer beam, asynchronous, 1 = blocked
//   BTN_B    inner beam, asynchronous, 1 = blocked
//   CLR      synchronous clear of COUNT (FSM keeps tracking)
//   COUNT    current occupancy
//   FULL     COUNT == CAPACITY
//   EMPTY    COUNT == 0
//   ALMOST   COUNT >= ALMOST_TH
//   ENTRY_P  one-cycle pulse, accepted entry
//   EXIT_P   one-cycle pulse, accepted exit
//   REJ_P    one-cycle pulse, entry while full or exit while empty
//   SEQ_ERR  one-cycle pulse on entering the error state
module contador_ocupacion #(
    parameter int CAPACITY   = 7,
    parameter int CNT_W      = 3,
    parameter int ALMOST_TH  = 5,
    parameter int DEB_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_A,
    input  logic             BTN_B,
    input  logic             CLR,
    output logic [CNT_W-1:0] COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST,
    output logic             ENTRY_P,
    output logic             EXIT_P,
    output logic             REJ_P,
    output logic             SEQ_ERR
);

    // Debounce counter only has to reach DEB_CYCLES-1.
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ATH      = CNT_W'(ALMOST_TH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_E1   = 3'd1;
    localparam logic [2:0] S_E2   = 3'd2;
    localparam logic [2:0] S_E3   = 3'd3;
    localparam logic [2:0] S_X1   = 3'd4;
    localparam logic [2:0] S_X2   = 3'd5;
    localparam logic [2:0] S_X3   = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    // Bit 1 carries beam A, bit 0 beam B, so case labels read as {A,B}.
    logic [1:0]    pins;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [DW-1:0] dcnt [2];

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          entry_evt;
    logic          exit_evt;

    logic [CNT_W-1:0] count;

    assign pins = {BTN_A, BTN_B};

    // ------------------------------------------------------------------
    // Synchroniser + debouncer. The counter only runs while the synchronised
    // level disagrees with the debounced one, so any glitch shorter than
    // DEB_CYCLES resets it and leaves the debounced level untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            deb     <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    deb[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Direction FSM on the debounced pair. Unlisted patterns (including the
    // state's own pattern) keep the current state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                case (deb)
                    2'b10:   state_nxt = S_E1;
                    2'b01:   state_nxt = S_X1;
                    2'b11:   state_nxt = S_ERR;
                    default: state_nxt = state;
                endcase
            end
            S_E1: begin
                case (deb)
                    2'b11:   state_nxt = S_E2;
                    2'b00:   state_nxt = S_IDLE;
                    2'b01:   state_nxt = S_ERR;
                    default: state_nxt = state;
                endcase
            end
            S_E2: begin
                case (deb)
                    2'b01:   state_nxt = S_E3;
                    2'b10:   state_nxt = S_E1;
                    2'b00:   state_nxt = S_ERR;
                    default: state_nxt = state;
                endcase
            end
            S_E3: begin
                case (deb)
                    2'b00:   state_nxt = S_IDLE;
                    2'b11:   state_nxt = S_E2;
                    2'b10:   state_nxt = S_ERR;
                    default: state_nxt = state;
                endcase
            end
            S_X1: begin
                case (deb)
                    2'b11:   state_nxt = S_X2;
                    2'b00:   state_nxt = S_IDLE;
                    2'b10:   state_nxt = S_ERR;
                    default: state_nxt = state;
                endcase
            end
            S_X2: begin
                case (deb)
                    2'b10:   state_nxt = S_X3;
                    2'b01:   state_nxt = S_X1;
                    2'b00:   state_nxt = S_ERR;
                    default: state_nxt = state;
                endcase
            end
            S_X3: begin
                case (deb)
                    2'b00:   state_nxt = S_IDLE;
                    2'b11:   state_nxt = S_X2;
                    2'b01:   state_nxt = S_ERR;
                    default: state_nxt = state;
                endcase
            end
            default: begin
                // S_ERR: only a fully clear gate resynchronises the FSM.
                if (deb == 2'b00) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // A sequence completes on the final transition back to idle.
    assign entry_evt = (state == S_E3) && (deb == 2'b00);
    assign exit_evt  = (state == S_X3) && (deb == 2'b00);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            SEQ_ERR <= 1'b0;
        end else begin
            state   <= state_nxt;
            SEQ_ERR <= (state_nxt == S_ERR) && (state != S_ERR);
        end
    end

    // ------------------------------------------------------------------
    // Saturating counter. CLR wins over a same-cycle event and suppresses
    // every pulse, so a cleared count never reports a stale accept/reject.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count   <= '0;
            ENTRY_P <= 1'b0;
            EXIT_P  <= 1'b0;
            REJ_P   <= 1'b0;
        end else begin
            ENTRY_P <= 1'b0;
            EXIT_P  <= 1'b0;
            REJ_P   <= 1'b0;
            if (CLR) begin
                count <= '0;
            end else if (entry_evt) begin
                if (count < CAP) begin
                    count   <= count + ONE;
                    ENTRY_P <= 1'b1;
                end else begin
                    REJ_P   <= 1'b1;
                end
            end else if (exit_evt) begin
                if (count != '0) begin
                    count  <= count - ONE;
                    EXIT_P <= 1'b1;
                end else begin
                    REJ_P  <= 1'b1;
                end
            end
        end
    end

    assign COUNT  = count;
    assign FULL   = (count == CAP);
    assign EMPTY  = (count == '0);
    assign ALMOST = (count >= ATH);

endmodule

// File: tb/tb_contador_ocupacion.sv
module tb_contador_ocupacion;

    localparam int CAPACITY   = 7;
    localparam int CNT_W      = 3;
    localparam int ALMOST_TH  = 5;
    localparam int DEB_CYCLES = 4;
    localparam int HOLD       = 10;

    localparam int K_ENTRY = 1;
    localparam int K_EXIT  = 2;
    localparam int K_REJ   = 3;
    localparam int K_SERR  = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             BTN_A = 1'b0;
    logic             BTN_B = 1'b0;
    logic             CLR = 1'b0;
    logic [CNT_W-1:0] COUNT;
    logic             FULL;
    logic             EMPTY;
    logic             ALMOST;
    logic             ENTRY_P;
    logic             EXIT_P;
    logic             REJ_P;
    logic             SEQ_ERR;

    int checks   = 0;
    int failures = 0;
    int model_cnt = 0;

    typedef struct {
        int kind;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    contador_ocupacion #(
        .CAPACITY  (CAPACITY),
        .CNT_W     (CNT_W),
        .ALMOST_TH (ALMOST_TH),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_A  (BTN_A),
        .BTN_B  (BTN_B),
        .CLR    (CLR),
        .COUNT  (COUNT),
        .FULL   (FULL),
        .EMPTY  (EMPTY),
        .ALMOST (ALMOST),
        .ENTRY_P(ENTRY_P),
        .EXIT_P (EXIT_P),
        .REJ_P  (REJ_P),
        .SEQ_ERR(SEQ_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pop the next expected event and compare it with the pulse just seen.
    task automatic on_pulse(input int kind);
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_pulse observed_kind=%0d count=%0d expected=none", kind, COUNT);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_count", COUNT, e.cnt);
        end
    endtask

    always @(negedge CLK) begin
        if (ENTRY_P) on_pulse(K_ENTRY);
        if (EXIT_P)  on_pulse(K_EXIT);
        if (REJ_P)   on_pulse(K_REJ);
        if (SEQ_ERR) on_pulse(K_SERR);
    end

    task automatic push(input int kind, input int cnt);
        exp_t e;
        e.kind = kind;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic level(input logic a, input logic b);
        BTN_A = a;
        BTN_B = b;
        repeat (HOLD) @(negedge CLK);
    endtask

    // Full entry; the model predicts accept or reject from the current count.
    task automatic do_entry();
        if (model_cnt < CAPACITY) begin
            model_cnt++;
            push(K_ENTRY, model_cnt);
        end else begin
            push(K_REJ, model_cnt);
        end
        level(1, 0); level(1, 1); level(0, 1); level(0, 0);
    endtask

    task automatic do_exit();
        if (model_cnt > 0) begin
            model_cnt--;
            push(K_EXIT, model_cnt);
        end else begin
            push(K_REJ, model_cnt);
        end
        level(0, 1); level(1, 1); level(1, 0); level(0, 0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_count"},  COUNT,  model_cnt);
        check({tag, "_full"},   FULL,   model_cnt == CAPACITY);
        check({tag, "_empty"},  EMPTY,  model_cnt == 0);
        check({tag, "_almost"}, ALMOST, model_cnt >= ALMOST_TH);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check_flags("reset");
        check("reset_pulses", {ENTRY_P, EXIT_P, REJ_P, SEQ_ERR}, 4'b0000);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        // Clean entry
        do_entry();
        check_flags("entry1");

        // Bring count to 3, then reset while the FSM sits in S_E2
        do_entry();
        do_entry();
        check_flags("count3");
        level(1, 0);
        level(1, 1);
        #2 RST = 1'b0;
        #1;
        model_cnt = 0;
        check_flags("async_rst");
        check("async_rst_state", dut.state, 0);
        BTN_A = 1'b0;
        BTN_B = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        // B-only start must be an exit: rejected since the gate is empty
        do_exit();
        check_flags("post_rst_exit");

        // Fill to capacity watching ALMOST/FULL on every step, then overflow
        for (int i = 0; i < CAPACITY; i++) begin
            do_entry();
            check_flags($sformatf("fill%0d", i + 1));
        end
        do_entry();
        check_flags("overflow");
        do_exit();
        check_flags("exit_from_full");

        // Backing up still counts as one entry
        push(K_ENTRY, ++model_cnt);
        level(1, 0); level(1, 1); level(1, 0); level(1, 1); level(0, 1); level(0, 0);
        check_flags("backup");

        // Abort: no pulse
        level(1, 0); level(0, 0);
        check_flags("abort");

        // Jump 10 -> 01: error; further patterns ignored until 00
        push(K_SERR, model_cnt);
        level(1, 0); level(0, 1);
        level(1, 1); level(0, 1); level(0, 0);
        check_flags("seq_err");
        check("seq_err_idle", dut.state, 0);
        do_exit();
        check_flags("recover_exit");

        // Short glitch on A is invisible
        BTN_A = 1'b1;
        repeat (2) @(negedge CLK);
        BTN_A = 1'b0;
        repeat (HOLD) @(negedge CLK);
        check("glitch_deb_a", dut.deb[1], 1'b0);
        check("glitch_state", dut.state, 0);
        check_flags("glitch");

        // Down to 4, then clear on the completing edge of an entry
        while (model_cnt > 4) do_exit();
        check_flags("count4");
        level(1, 0); level(1, 1); level(0, 1);
        BTN_A = 1'b0;
        BTN_B = 1'b0;
        repeat (5) @(negedge CLK);
        CLR = 1'b1;
        repeat (3) @(negedge CLK);
        CLR = 1'b0;
        model_cnt = 0;
        repeat (HOLD) @(negedge CLK);
        check_flags("clr_priority");

        // Exit at zero rejects and holds
        do_exit();
        check_flags("exit_at_zero");

        repeat (HOLD) @(negedge CLK);
        check("pending_events", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
